// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial-by-stage logical left shifter.
// Optional feature macro: ALU_SLL_ZERO_SKIP_EN (zero-shift fast path).
package alu_pkg;

  // Default operand/result width of the shifter datapath.
  localparam int XLEN_DEFAULT = 32;

  // Controller states: waiting for a request, walking the shift stages,
  // and presenting the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Distance moved by one stage: stage k shifts by 2**k bit positions.
  function automatic int stageDistance(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/alu_sll_stage.sv
// One stage of the logarithmic left shifter. Stage k either passes the
// value through or shifts it left by 2**k positions with zero fill.
// Optional feature macro: ALU_SLL_ZERO_SKIP_EN (not used in this file).
module alu_sll_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  k_i,
  input  logic            en_i,
  output logic [XLEN-1:0] data_o
);

  logic [SHW-1:0] distance;

  // Stage distance is a power of two selected by the stage index; the
  // largest distance (XLEN/2) still fits in SHW bits.
  always_comb begin
    distance = SHW'(1) << k_i;
  end

  // Apply the stage only when the matching shift-amount bit is set.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = data_i << distance;
    end
  end

endmodule

// File: rtl/alu_sll_seq.sv
// Sequential logical-left-shift unit. A request captured in IDLE is
// processed one binary stage per clock, most significant stage first,
// so every non-trivial shift takes the same number of cycles.
// Optional feature macro: ALU_SLL_ZERO_SKIP_EN -- when defined, a request
// with a zero shift amount completes straight from IDLE without entering
// the SHIFT state.
module alu_sll_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  state_e          state_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  shamt_q;
  logic [SHW-1:0]  k_q;
  logic [XLEN-1:0] rd_q;
  logic            busy_q;
  logic            done_q;

  logic [XLEN-1:0] acc_d;
  logic            stageEn;
  logic [SHW-1:0]  shamtIn;
  logic            unusedRs2;

  // Only the low SHW bits of the amount matter; the rest are dropped.
  assign shamtIn   = rs2[SHW-1:0];
  assign unusedRs2 = ^rs2[XLEN-1:SHW];

  // The current stage fires when its bit of the captured amount is set.
  assign stageEn = shamt_q[k_q];

  alu_sll_stage #(
    .XLEN (XLEN)
  ) uStage (
    .data_i (acc_q),
    .k_i    (k_q),
    .en_i   (stageEn),
    .data_o (acc_d)
  );

  // Controller and datapath registers: capture in IDLE, one stage per edge
  // in SHIFT, publish the result and pulse done on the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= rs1;
            shamt_q <= shamtIn;
            k_q     <= SHW'(SHW - 1);
`ifdef ALU_SLL_ZERO_SKIP_EN
            if (shamtIn == '0) begin
              state_q <= DONE;
              rd_q    <= rs1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
`else
            begin
`endif
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          if (k_q == '0) begin
            state_q <= DONE;
            rd_q    <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rd   = rd_q;

endmodule

// File: tb/tb_alu_sll_seq.sv
// Scoreboard bench for the sequential left shifter: expected results are
// queued as requests are issued and compared when done is observed.
module tb_alu_sll_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int checkCount;
  int failCount;
  int zeroLat;
  logic [31:0] expQ[$];
  logic [31:0] lastRd;

  alu_sll_seq #(
    .XLEN (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a request on the falling edge and record its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected);
    @(negedge clk);
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    expQ.push_back(expected);
  endtask

  // Issue one request and follow it to completion, checking latency,
  // busy duration, result, hold of the previous result and pulse width.
  // With disturb set, start and operands are scrambled while busy.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expected, input bit disturb);
    int edges;
    int busyCycles;
    int expLat;
    int extraDone;
    bit seen;
    logic [31:0] want;
    expLat = (b[4:0] == 5'd0) ? zeroLat : 6;
    applyStimulus(a, b, expected);
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    seen = 1'b0;
    busyCycles = 0;
    while (!seen && edges < 20) begin
      @(negedge clk);
      if (edges == 1) checkOutput("rdHold", rd, lastRd);
      if (busy) busyCycles++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        if (disturb && busy) begin
          start = 1'b1;
          rs1 = $urandom;
          rs2 = $urandom;
        end
        @(posedge clk);
        edges++;
      end
    end
    want = expQ.pop_front();
    if (!seen) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(edges), 32'(expLat));
      checkOutput("busyCycles", 32'(busyCycles), 32'(expLat - 1));
      checkOutput("rd", rd, want);
      lastRd = want;
      @(negedge clk);
      checkOutput("donePulse", {31'd0, done}, 32'd0);
    end
    if (disturb) begin
      extraDone = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done) extraDone++;
      end
      checkOutput("singleDone", 32'(extraDone), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int doneAfterReset;
    logic [31:0] ra;
    logic [31:0] rb;

    checkCount = 0;
    failCount  = 0;
`ifdef ALU_SLL_ZERO_SKIP_EN
    zeroLat = 1;
`else
    zeroLat = 6;
`endif
    vecs[0] = '{32'd1431655765, 32'd1,  32'd2863311530};
    vecs[1] = '{32'd1431655765, 32'd10, 32'd1431655424};
    vecs[2] = '{32'd1431655765, 32'd72, 32'd1431655680};
    vecs[3] = '{32'd4294967295, 32'd3,  32'd4294967288};
    vecs[4] = '{32'd1,          32'd31, 32'd2147483648};
    vecs[5] = '{32'd1,          32'd0,  32'd1};

    rst_n = 1'b0;
    start = 1'b0;
    rs1 = '0;
    rs2 = '0;
    lastRd = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetRd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) runOp(vecs[i].a, vecs[i].b, vecs[i].e, 1'b0);

    $display("[TB] random vectors");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      runOp(ra, rb, ra << rb[4:0], 1'b0);
    end

    $display("[TB] requests while busy are ignored");
    runOp(32'h0000_00F3, 32'd5, 32'h0000_1E60, 1'b1);

    $display("[TB] reset during shift");
    @(negedge clk);
    rs1 = 32'h1234_5678;
    rs2 = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortRd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneAfterReset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneAfterReset++;
    end
    checkOutput("abortNoDone", 32'(doneAfterReset), 32'd0);
    checkOutput("abortRdHeld", rd, 32'd0);
    lastRd = '0;

    $display("[TB] first request after reset release");
    runOp(32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_sll_seq.md
ALU_SLL_SEQ -- requirements
Module: alu_sll_seq

Interface
- REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
- REQ-002 SHALL have derived localparam SHW = $clog2(XLEN), default 5, shift-amount width.
- REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
- REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
- REQ-006 SHALL have port rs1, input, XLEN, value to shift.
- REQ-007 SHALL have port rs2, input, XLEN, shift amount; only rs2[SHW-1:0] used.
- REQ-008 SHALL have port busy, output, 1, high while a shift is in progress (SHIFT state).
- REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
- REQ-010 SHALL have port rd, output, XLEN, result: rs1 logically shifted left, zero fill.

Function
- REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
- REQ-012 In IDLE with start=1 at a rising edge, SHALL latch rs1 into internal acc, latch rs2[SHW-1:0] into shamt, set stage index k=SHW-1, and enter SHIFT.
- REQ-013 In SHIFT, each edge SHALL set acc = shamt[k] ? acc << (1<<k) : acc, then decrement k; after the stage k=0 edge, the FSM SHALL enter DONE and load rd with the final acc.
- REQ-014 Latency SHALL be fixed: done high for exactly one cycle, beginning SHW+1 rising edges after the accepting edge (6 for XLEN=32), independent of shamt (except REQ-024).
- REQ-015 DONE SHALL return to IDLE on the next edge unconditionally.
- REQ-016 start SHALL be ignored in SHIFT and DONE; rs1/rs2 changes after acceptance SHALL NOT affect the result.
- REQ-017 rd SHALL change only on the completing edge and SHALL hold its value until the next completion.
- REQ-018 Bits shifted beyond bit XLEN-1 SHALL be discarded; rs2 bits above SHW-1 SHALL be ignored (rs2=72 shifts by 8).
- REQ-019 busy SHALL be high iff state==SHIFT; done SHALL be high iff state==DONE.

Reset
- REQ-020 rst_n low SHALL asynchronously force state=IDLE, rd=0, acc=0, shamt=0, k=0, busy=0, done=0.
- REQ-021 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and rd SHALL read 0.
- REQ-022 After reset release, the first rising edge with start=1 SHALL be accepted.

Configuration
- REQ-023 Macro ALU_SLL_ZERO_SKIP_EN SHALL select zero-shift fast path.
- REQ-024 With ALU_SLL_ZERO_SKIP_EN defined, an accepted request with shamt==0 SHALL go IDLE->DONE directly, loading rd=rs1, done high 1 edge after acceptance, busy never high.
- REQ-025 Without ALU_SLL_ZERO_SKIP_EN, shamt==0 SHALL take the full REQ-014 latency with rd=rs1.

Structure
- REQ-026 Package alu_pkg SHALL hold XLEN default and the FSM state enum type (IDLE/SHIFT/DONE).
- REQ-027 Sub-module alu_sll_stage (combinational: in, k, en -> out = en ? in << (1<<k) : in) SHALL perform one stage and be instantiated once.

Verification
- REQ-028 rs1=1431655765, rs2=1, start pulse -> done after 6 edges, rd=2863311530, busy high 5 cycles.
- REQ-029 rs1=1431655765, rs2=10 -> rd=1431655424; rs2=72 -> rd=1431655680 (upper bits ignored).
- REQ-030 rs1=4294967295, rs2=3 -> rd=4294967288; then rs1=1, rs2=31 -> rd=2147483648.
- REQ-031 Start pulse and new rs1/rs2 values during busy -> ignored; the original result is delivered; exactly one done pulse.
- REQ-032 rst_n low two edges into SHIFT -> busy=0, done=0, rd=0 immediately, with no later done pulse.
- REQ-033 rs1=1, rs2=0 -> rd=1; done 1 edge after acceptance with ALU_SLL_ZERO_SKIP_EN defined, 6 edges without it.
